// File: rtl/dff8_arb_pkg.sv
// rtl/dff8_arb_pkg.sv - shared defaults, types and helpers for the dff8 write arbiter
package dff8_arb_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_N     = 4;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_IW    = $clog2(DEF_N);

    typedef logic [DEF_W-1:0]  data_t;
    typedef logic [DEF_IW-1:0] idx_t;

    // One-hot vector for a requester index at the default requester count
    function automatic logic [DEF_N-1:0] onehot(idx_t i);
        logic [DEF_N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dff8_rr_pick.sv
// rtl/dff8_rr_pick.sv - combinational rotate-priority picker starting at ptr
module dff8_rr_pick
    import dff8_arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan offsets from farthest to nearest so the requester closest to ptr wins
    always_comb begin
        logic [IW:0] pos;
        pos = '0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (req[pos[IW-1:0]]) begin
                idx = pos[IW-1:0];
                any = 1'b1;
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dff8_write_arbiter.sv
// rtl/dff8_write_arbiter.sv - round-robin write arbiter in front of a shared register; grant lock under DFF8_ARB_LOCK_EN
module dff8_write_arbiter
    import dff8_arb_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W,
    parameter int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           areset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    input  logic [N-1:0]   lock,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic           q_valid,
    output logic [IW-1:0]  last_src,
    output logic [CNT_W-1:0] wr_count
);

    logic [IW-1:0]    ptr_q, ptr_d;
    logic [W-1:0]     q_q, q_d;
    logic             valid_q, valid_d;
    logic [IW-1:0]    src_q, src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             lock_hold;

    dff8_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef DFF8_ARB_LOCK_EN
    assign lock_hold = lock[pick_idx];
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign lock_hold   = 1'b0;
`endif

    // Next state: capture the winner's data and advance the pointer, else hold everything
    always_comb begin
        ptr_d   = ptr_q;
        q_d     = q_q;
        valid_d = valid_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        if (pick_any) begin
            q_d     = wdata[int'(pick_idx) * W +: W];
            src_d   = pick_idx;
            valid_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (lock_hold) begin
                ptr_d = pick_idx;
            end else if (pick_idx == IW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_idx + IW'(1);
            end
        end
    end

    // State registers; reset clears them immediately so no partial write survives
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ptr_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q        = q_q;
    assign q_valid  = valid_q;
    assign last_src = src_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_dff8_write_arbiter.sv
// tb/tb_dff8_write_arbiter.sv - directed self-checking bench for dff8_write_arbiter
module tb_dff8_write_arbiter;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  lock;

    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        q_valid;
    logic [1:0]  last_src;
    logic [15:0] wr_count;

    logic [3:0]  s_gnt;
    logic [7:0]  s_q;
    logic        s_q_valid;
    logic [1:0]  s_last_src;
    logic [1:0]  s_wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dff8_write_arbiter #(.W(8), .N(4), .CNT_W(16)) dut (
        .clk      (clk),
        .areset   (areset),
        .req      (req),
        .wdata    (wdata),
        .lock     (lock),
        .gnt      (gnt),
        .q        (q),
        .q_valid  (q_valid),
        .last_src (last_src),
        .wr_count (wr_count)
    );

    dff8_write_arbiter #(.W(8), .N(4), .CNT_W(2)) dut_sat (
        .clk      (clk),
        .areset   (areset),
        .req      (req),
        .wdata    (wdata),
        .lock     (lock),
        .gnt      (s_gnt),
        .q        (s_q),
        .q_valid  (s_q_valid),
        .last_src (s_last_src),
        .wr_count (s_wr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_gnt3 [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    logic [7:0] exp_q3   [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13};
    logic [3:0] lk5      [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
`ifdef DFF8_ARB_LOCK_EN
    logic [3:0] exp_gnt5 [4] = '{4'h1, 4'h1, 4'h1, 4'h2};
`else
    logic [3:0] exp_gnt5 [4] = '{4'h1, 4'h2, 4'h1, 4'h2};
`endif
    logic [7:0] s_dat    [3] = '{8'h50, 8'h51, 8'h52};

    initial begin
        areset = 1'b1;
        req    = '0;
        wdata  = '0;
        lock   = '0;
        #12;
        check("rst_q", 32'(q), 32'h0);
        check("rst_valid", 32'(q_valid), 32'h0);
        check("rst_cnt", 32'(wr_count), 32'h0);
        check("rst_src", 32'(last_src), 32'h0);
        check("rst_gnt_idle", 32'(gnt), 32'h0);
        areset = 1'b0;
        tick;

        // single requester 2
        req   = 4'b0100;
        wdata = {8'h00, 8'h3C, 8'h00, 8'h00};
        #1;
        check("t2_gnt", 32'(gnt), 32'h4);
        tick;
        req = '0;
        check("t2_q", 32'(q), 32'h3C);
        check("t2_src", 32'(last_src), 32'h2);
        check("t2_valid", 32'(q_valid), 32'h1);
        check("t2_cnt", 32'(wr_count), 32'h1);

        // ptr=3, wrap to 0, then idle hold
        req   = 4'b1001;
        wdata = {8'h33, 8'h22, 8'h11, 8'h30};
        #1;
        check("t4_gnt3", 32'(gnt), 32'h8);
        tick;
        check("t4_q3", 32'(q), 32'h33);
        check("t4_src3", 32'(last_src), 32'h3);
        check("t4_gnt0", 32'(gnt), 32'h1);
        tick;
        check("t4_q0", 32'(q), 32'h30);
        check("t4_src0", 32'(last_src), 32'h0);
        req = '0;
        #1;
        check("t4_gnt_idle", 32'(gnt), 32'h0);
        tick;
        tick;
        check("t4_hold_q", 32'(q), 32'h30);
        check("t4_hold_cnt", 32'(wr_count), 32'h3);
        check("t4_hold_src", 32'(last_src), 32'h0);
        req = 4'b1001;
        #1;
        check("t4_hold_ptr", 32'(gnt), 32'h8);
        tick;
        req = '0;
        check("t4_q_after", 32'(q), 32'h33);

        // all requesting: rotation
        req   = 4'b1111;
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int c = 0; c < 8; c++) begin
            #1;
            check($sformatf("t3_gnt%0d", c), 32'(gnt), 32'(exp_gnt3[c]));
            tick;
            check($sformatf("t3_q%0d", c), 32'(q), 32'(exp_q3[c]));
        end
        req = '0;
        check("t3_cnt", 32'(wr_count), 32'd12);

        // lock hint
        req   = 4'b0011;
        wdata = {8'h00, 8'h00, 8'h21, 8'h20};
        for (int c = 0; c < 4; c++) begin
            lock = lk5[c];
            #1;
            check($sformatf("t5_gnt%0d", c), 32'(gnt), 32'(exp_gnt5[c]));
            tick;
        end
        req  = '0;
        lock = '0;
        check("t5_cnt", 32'(wr_count), 32'd16);

        // async reset mid-cycle with pending requests
        req   = 4'b0001;
        wdata = {8'h00, 8'h00, 8'h00, 8'hA5};
        tick;
        check("t1_pre_q", 32'(q), 32'hA5);
        req = 4'b1111;
        #3;
        areset = 1'b1;
        #1;
        check("t1_async_q", 32'(q), 32'h0);
        check("t1_async_valid", 32'(q_valid), 32'h0);
        check("t1_async_cnt", 32'(wr_count), 32'h0);
        check("t1_async_src", 32'(last_src), 32'h0);
        check("t1_async_gnt", 32'(gnt), 32'h1);
        check("t1_async_scnt", 32'(s_wr_count), 32'h0);
        tick;
        check("t1_inreset_q", 32'(q), 32'h0);
        areset = 1'b0;
        #1;
        check("t1_restart_gnt", 32'(gnt), 32'h1);
        tick;
        req = '0;
        check("t1_after_q", 32'(q), 32'hA5);
        check("t1_after_cnt", 32'(wr_count), 32'h1);

        // saturation on a 2-bit counter instance
        req   = 4'b0010;
        wdata = {8'h00, 8'h00, 8'h41, 8'h00};
        tick;
        check("t6_prime_cnt", 32'(s_wr_count), 32'h2);
        for (int c = 0; c < 3; c++) begin
            wdata = {8'h00, 8'h00, s_dat[c], 8'h00};
            tick;
            check($sformatf("t6_q%0d", c), 32'(s_q), 32'(s_dat[c]));
            check($sformatf("t6_cnt%0d", c), 32'(s_wr_count), 32'h3);
        end
        req = '0;
        check("t6_main_cnt", 32'(wr_count), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
